// File: rtl/pin_pkg.sv
// Shared definitions for the PIN-entry front end: FSM state encoding and BCD limits.
package pin_pkg;

    typedef enum logic [1:0] {
        ESPERA   = 2'd0,
        ENTRADA  = 2'd1,
        COMPARA  = 2'd2,
        BLOQUEIO = 2'd3
    } estado_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/temporizador_inatividade.sv
// Idle timer for PIN entry: counts cycles while active, restarts on every key,
// and flags expiry once the count reaches TIMEOUT_CICLOS-1.
module temporizador_inatividade #(
    parameter int TIMEOUT_CICLOS = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ativo,
    input  logic limpa,
    output logic expira
);
    localparam int CW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [CW-1:0] LIMITE = CW'(TIMEOUT_CICLOS - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Saturates at LIMITE so a stalled FSM never sees the count wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (!ativo || limpa) begin
            cnt_d = '0;
        end else if (cnt_q != LIMITE) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expira = ativo && (cnt_q == LIMITE);

endmodule

// File: rtl/comparador_pin.sv
// PIN-entry front end: collects keypad digits, compares against the stored PIN,
// pulses match/mismatch and locks out entry once the attempt counter ejects.
module comparador_pin
    import pin_pkg::*;
#(
    parameter int DIGITOS        = 4,
    parameter int TIMEOUT_CICLOS = 1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tecla_valida,
    input  logic [3:0]             tecla,
    input  logic                   confirma,
    input  logic                   apaga,
    input  logic [4*DIGITOS-1:0]   pin_ref,
    input  logic                   ejeta,
    output logic                   saida_comparador,
    output logic                   acesso_ok,
    output logic [3:0]             n_digitos,
    output logic                   bloqueado
);
    localparam int         BW    = 4 * DIGITOS;
    localparam logic [3:0] N_MAX = 4'(DIGITOS);

    estado_t       estado_q, estado_d;
    logic [BW-1:0] buf_q, buf_d;
    logic [3:0]    n_q, n_d;
    logic          ok_q, ok_d;
    logic          mis_q, mis_d;
    logic          pend_q, pend_d;
    logic          digito_ok;
    logic          em_entrada;
    logic          expira;

    assign digito_ok  = tecla_valida && (tecla <= BCD_MAX);
    assign em_entrada = (estado_q == ENTRADA);

    temporizador_inatividade #(
        .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
    ) u_temporizador (
        .clk    (clk),
        .rst_n  (rst_n),
        .ativo  (em_entrada),
        .limpa  (digito_ok),
        .expira (expira)
    );

    always_comb begin
        estado_d = estado_q;
        buf_d    = buf_q;
        n_d      = n_q;
        ok_d     = 1'b0;
        mis_d    = 1'b0;
        pend_d   = 1'b0;
        unique case (estado_q)
            ESPERA: begin
                // A short confirm leaves its mismatch pending so it lines up with COMPARA timing.
                mis_d = pend_q;
                if (digito_ok) begin
                    buf_d[3:0] = tecla;
                    n_d        = 4'd1;
                    estado_d   = ENTRADA;
                end
            end
            ENTRADA: begin
                if (apaga) begin
                    buf_d    = '0;
                    n_d      = '0;
                    estado_d = ESPERA;
                end else if (confirma) begin
                    if (n_q == N_MAX) begin
                        estado_d = COMPARA;
                    end else begin
                        buf_d    = '0;
                        n_d      = '0;
                        pend_d   = 1'b1;
                        estado_d = ESPERA;
                    end
                end else if (digito_ok) begin
                    if (n_q < N_MAX) begin
                        for (int i = 0; i < DIGITOS; i++) begin
                            if (n_q == 4'(i)) buf_d[4*i +: 4] = tecla;
                        end
                        n_d = n_q + 4'd1;
                    end
                end else if (expira) begin
                    buf_d    = '0;
                    n_d      = '0;
                    estado_d = ESPERA;
                end
            end
            COMPARA: begin
                if (buf_q == pin_ref) ok_d = 1'b1;
                else                  mis_d = 1'b1;
                buf_d    = '0;
                n_d      = '0;
                estado_d = ESPERA;
            end
            BLOQUEIO: begin
            end
            default: estado_d = ESPERA;
        endcase
        // Eject wins over everything, including a pulse due on this edge.
        if (ejeta) begin
            estado_d = BLOQUEIO;
            buf_d    = '0;
            n_d      = '0;
            ok_d     = 1'b0;
            mis_d    = 1'b0;
            pend_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q <= ESPERA;
            buf_q    <= '0;
            n_q      <= '0;
            ok_q     <= 1'b0;
            mis_q    <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            buf_q    <= buf_d;
            n_q      <= n_d;
            ok_q     <= ok_d;
            mis_q    <= mis_d;
            pend_q   <= pend_d;
        end
    end

    assign saida_comparador = mis_q;
    assign acesso_ok        = ok_q;
    assign n_digitos        = n_q;
    assign bloqueado        = (estado_q == BLOQUEIO);

endmodule
